nx_node_outbound: RTL

NX_NODE_OUTBOUND -- requirements
Module: nx_node_outbound

---
 rtl/nx_node_outbound_if.sv | 64 ++++++
 rtl/nx_node_outbound.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/nx_node_outbound_if.sv
// Message types and the core/egress bundle for the nx_node_outbound block.
// A message carries a header (target and source coordinates) and a payload.
// Handshake rule for every channel here: a transfer happens on a rising edge
// where valid and ready are both high; valid never waits on ready, and the
// sender holds data and valid stable until that edge.
package nx_node_pkg;
  typedef logic [3:0] coord_t;

  typedef struct packed {
    coord_t row;
    coord_t column;
  } node_coord_t;

  typedef struct packed {
    node_coord_t target;
    node_coord_t source;
  } node_header_t;

  typedef struct packed {
    node_header_t header;
    logic [15:0]  payload;
  } node_message_t;
endpackage

interface nx_node_outbound_if;
  import nx_node_pkg::*;

  // core -> FIFO
  node_message_t i_msg_data;
  logic          i_msg_valid;
  logic          o_msg_ready;

  // FIFO head -> four egress ports
  node_message_t o_north_data;
  node_message_t o_east_data;
  node_message_t o_south_data;
  node_message_t o_west_data;
  logic          o_north_valid;
  logic          o_east_valid;
  logic          o_south_valid;
  logic          o_west_valid;
  logic          i_north_ready;
  logic          i_east_ready;
  logic          i_south_ready;
  logic          i_west_ready;

  // Core and downstream links (the environment)
  modport master (
    output i_msg_data, i_msg_valid,
    output i_north_ready, i_east_ready, i_south_ready, i_west_ready,
    input  o_msg_ready,
    input  o_north_data, o_east_data, o_south_data, o_west_data,
    input  o_north_valid, o_east_valid, o_south_valid, o_west_valid
  );

  // The outbound block itself
  modport slave (
    input  i_msg_data, i_msg_valid,
    input  i_north_ready, i_east_ready, i_south_ready, i_west_ready,
    output o_msg_ready,
    output o_north_data, o_east_data, o_south_data, o_west_data,
    output o_north_valid, o_east_valid, o_south_valid, o_west_valid
  );
endinterface

// File: rtl/nx_node_outbound.sv
// nx_node_outbound: egress FIFO that routes each message from the execution
// core to one of four neighbour links by comparing its target coordinates
// with this node's coordinates (row first, then column). Self-addressed
// messages are dropped and flagged.
// Optional macro NX_OUTBOUND_STATS_EN: when defined, o_sent_count counts
// egress handshakes (saturating); otherwise it is tied to zero.
module nx_node_outbound
  import nx_node_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  coord_t              i_node_row,
  input  coord_t              i_node_col,
  nx_node_outbound_if.slave   bus,
  output logic                o_idle,
  output logic                o_self_drop,
  output logic [15:0]         o_sent_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    RT_NORTH,
    RT_EAST,
    RT_SOUTH,
    RT_WEST,
    RT_SELF
  } route_t;

  node_message_t mem [FIFO_DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop_now;
  logic          head_valid;
  logic          sel_ready;
  node_message_t head;
  route_t        route_calc;
  route_t        route_q;
  route_t        route_sel;
  logic          presented_q;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];

  // Route the current head against this node's coordinates
  always_comb begin
    route_calc = RT_SELF;
    if (head.header.target.row < i_node_row)
      route_calc = RT_NORTH;
    else if (head.header.target.row > i_node_row)
      route_calc = RT_SOUTH;
    else if (head.header.target.column < i_node_col)
      route_calc = RT_WEST;
    else if (head.header.target.column > i_node_col)
      route_calc = RT_EAST;
  end

  // Once a head is on an egress port its direction is frozen, so a change of
  // node coordinates cannot move a message that a neighbour is already seeing.
  assign route_sel  = presented_q ? route_q : route_calc;
  assign head_valid = !empty && (route_sel != RT_SELF);
  assign drop_now   = !empty && (route_sel == RT_SELF);

  // Pick the ready of the selected direction
  always_comb begin
    sel_ready = 1'b0;
    case (route_sel)
      RT_NORTH: sel_ready = bus.i_north_ready;
      RT_EAST:  sel_ready = bus.i_east_ready;
      RT_SOUTH: sel_ready = bus.i_south_ready;
      RT_WEST:  sel_ready = bus.i_west_ready;
      default:  sel_ready = 1'b0;
    endcase
  end

  assign pop             = drop_now || (head_valid && sel_ready);
  assign bus.o_msg_ready = !full && !i_rst;
  assign push            = bus.i_msg_valid && bus.o_msg_ready;

  assign bus.o_north_data  = head;
  assign bus.o_east_data   = head;
  assign bus.o_south_data  = head;
  assign bus.o_west_data   = head;
  assign bus.o_north_valid = head_valid && (route_sel == RT_NORTH);
  assign bus.o_east_valid  = head_valid && (route_sel == RT_EAST);
  assign bus.o_south_valid = head_valid && (route_sel == RT_SOUTH);
  assign bus.o_west_valid  = head_valid && (route_sel == RT_WEST);

  assign o_idle = empty;

  // FIFO storage and wrapping pointers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= bus.i_msg_data;
        wptr              <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  // Track whether the current head has been shown and latch its direction
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      presented_q <= 1'b0;
      route_q     <= RT_NORTH;
    end else if (pop) begin
      presented_q <= 1'b0;
    end else if (head_valid) begin
      presented_q <= 1'b1;
      route_q     <= route_sel;
    end
  end

  // Sticky self-drop flag, cleared only by reset
  always_ff @(posedge i_clk) begin
    if (i_rst)         o_self_drop <= 1'b0;
    else if (drop_now) o_self_drop <= 1'b1;
  end

`ifdef NX_OUTBOUND_STATS_EN
  logic [15:0] sent_q;

  // Count egress handshakes, saturating at all ones
  always_ff @(posedge i_clk) begin
    if (i_rst)
      sent_q <= '0;
    else if (head_valid && sel_ready && (sent_q != 16'hFFFF))
      sent_q <= sent_q + 16'd1;
  end

  assign o_sent_count = sent_q;
`else
  assign o_sent_count = 16'd0;
`endif

endmodule
